// File: rtl/q_value_updater.sv
// q_value_updater
//   Write-back half of the Q-learning datapath. One start request performs a
//   single Bellman update of Q(s,a) on the Q-table RAM's second port:
//     1. Read row s and pick lane a           -> q_cur
//     2. Read row s' and take the signed max  -> q_max (0 if s' is terminal)
//     3. q_new = q_cur + ((r + gamma*q_max - q_cur) >>> ALPHA_SHIFT),
//        where gamma*x = x - (x >>> GAMMA_SHIFT)
//     4. Write the single Q_W-bit lane back
//   The latency is fixed. If start is accepted at edge 0, wr_en is high in
//   cycle 5 and done is high in cycle 6.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               request pulse, sampled only in IDLE
//   state, action       s, a
//   reward              signed r
//   next_state          s'
//   terminal            s' terminal, so its max Q is taken as 0
//   busy, done          status (busy RD_CUR..WRITE, done one-cycle pulse)
//   rd_en, rd_addr      row read request, data returns one cycle later
//   rd_data             4*Q_W row, lane i = action i
//   wr_en, wr_addr,
//   wr_lane, wr_data    single-lane write strobe
//
// Build option
//   Q_UPDATER_SATURATE_EN  clamp q_new to the Q_W signed range. When the macro
//                          is undefined, q_new wraps (the low Q_W bits are kept).
module q_value_updater #(
  parameter int STATE_W     = 6,
  parameter int Q_W         = 16,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] state,
  input  logic [1:0]         action,
  input  logic [Q_W-1:0]     reward,
  input  logic [STATE_W-1:0] next_state,
  input  logic               terminal,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [STATE_W-1:0] rd_addr,
  input  logic [4*Q_W-1:0]   rd_data,
  output logic               wr_en,
  output logic [STATE_W-1:0] wr_addr,
  output logic [1:0]         wr_lane,
  output logic [Q_W-1:0]     wr_data
);

  localparam int NUM_LANES = 4;
  localparam int CW        = Q_W + 2;  // the worst-case Bellman terms fit in Q_W+2 bits

  typedef enum logic [2:0] {IDLE, RD_CUR, RD_NEXT, MAXQ, CALC, WRITE, DONE} st_t;

  st_t                 st;
  logic [STATE_W-1:0]  s_r, ns_r;
  logic [1:0]          a_r;
  logic [Q_W-1:0]      r_r;
  logic                term_r;
  logic [Q_W-1:0]      q_cur, q_max;

  logic [NUM_LANES-1:0][Q_W-1:0] lanes;
  assign lanes = rd_data;

  // Signed max over the row. Ties resolve to the same value, so the lane
  // that wins does not matter.
  logic signed [Q_W-1:0] row_max;
  always_comb begin
    row_max = lanes[0];
    for (int i = 1; i < NUM_LANES; i++)
      if ($signed(lanes[i]) > row_max) row_max = lanes[i];
  end

  // Bellman update in CW-bit signed arithmetic. The shifts floor toward -inf.
  logic signed [CW-1:0] qm_x, qc_x, r_x, g, target, delta, q_new;
  always_comb begin
    qm_x   = {{(CW-Q_W){q_max[Q_W-1]}}, q_max};
    qc_x   = {{(CW-Q_W){q_cur[Q_W-1]}}, q_cur};
    r_x    = {{(CW-Q_W){r_r[Q_W-1]}},   r_r};
    g      = qm_x - (qm_x >>> GAMMA_SHIFT);
    target = r_x + g;
    delta  = target - qc_x;
    q_new  = qc_x + (delta >>> ALPHA_SHIFT);
  end

  logic [Q_W-1:0] wr_next;
`ifdef Q_UPDATER_SATURATE_EN
  // The value is in range only when every bit above the Q_W sign bit
  // matches that sign bit.
  logic ovf;
  assign ovf = (q_new[CW-1:Q_W-1] != {(CW-Q_W+1){1'b0}}) &&
               (q_new[CW-1:Q_W-1] != {(CW-Q_W+1){1'b1}});
  always_comb begin
    if (!ovf)           wr_next = q_new[Q_W-1:0];
    else if (q_new[CW-1]) wr_next = {1'b1, {(Q_W-1){1'b0}}};
    else                wr_next = {1'b0, {(Q_W-1){1'b1}}};
  end
`else
  // Two's-complement wrap. The high bits are intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^q_new[CW-1:Q_W];
  assign wr_next   = q_new[Q_W-1:0];
`endif

  // Each output is registered on the edge that enters the state where that
  // output must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      s_r     <= '0;
      ns_r    <= '0;
      a_r     <= '0;
      r_r     <= '0;
      term_r  <= 1'b0;
      q_cur   <= '0;
      q_max   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_lane <= '0;
      wr_data <= '0;
    end else begin
      case (st)
        IDLE: if (start) begin
          s_r     <= state;
          ns_r    <= next_state;
          a_r     <= action;
          r_r     <= reward;
          term_r  <= terminal;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= state;
          st      <= RD_CUR;
        end
        RD_CUR: begin
          // For a terminal s', skip the second read but keep the fixed latency.
          rd_en   <= !term_r;
          rd_addr <= ns_r;
          st      <= RD_NEXT;
        end
        RD_NEXT: begin
          q_cur <= lanes[a_r];
          rd_en <= 1'b0;
          st    <= MAXQ;
        end
        MAXQ: begin
          q_max <= term_r ? '0 : row_max;
          st    <= CALC;
        end
        CALC: begin
          wr_en   <= 1'b1;
          wr_addr <= s_r;
          wr_lane <= a_r;
          wr_data <= wr_next;
          st      <= WRITE;
        end
        WRITE: begin
          wr_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          st    <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
